// File: rtl/fir_decim_fifo.sv
// Decimating accumulate-and-dump averager behind the FIR output, feeding a
// small first-word-fall-through FIFO with a valid/ready consumer interface.
module fir_decim_fifo #(
   parameter int NUM_INPUT_BITS = 16,
   parameter int LOG2_DECIM     = 2,
   parameter int FIFO_DEPTH     = 4
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic signed [NUM_INPUT_BITS-1:0]  in_sample,
   input  logic                              in_valid,
   output logic signed [NUM_INPUT_BITS-1:0]  out_data,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [$clog2(FIFO_DEPTH):0]       count,
   output logic                              overflow
);

   localparam int ACC_W = NUM_INPUT_BITS + LOG2_DECIM;
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);

   logic [LOG2_DECIM-1:0]            phase_reg, phase_next;
   logic signed [ACC_W-1:0]          acc_reg, acc_next;
   logic signed [ACC_W-1:0]          in_ext;
   logic signed [ACC_W-1:0]          sum;
   logic signed [NUM_INPUT_BITS-1:0] result;
   logic                             dump;

   logic [PTR_W-1:0]                 rd_ptr_reg, rd_ptr_next;
   logic [PTR_W-1:0]                 wr_ptr_reg, wr_ptr_next;
   logic [CNT_W-1:0]                 count_reg, count_next;
   logic                             overflow_reg, overflow_next;
   logic                             full, push, pop;
   logic signed [NUM_INPUT_BITS-1:0] mem [FIFO_DEPTH];

   // ------------------------------------------------------------------
   // Accumulate-and-dump
   // ------------------------------------------------------------------
   assign in_ext = {{LOG2_DECIM{in_sample[NUM_INPUT_BITS-1]}}, in_sample};
   assign sum    = acc_reg + in_ext;
   assign dump   = in_valid && (phase_reg == '1);

   // Taking the upper bits of the sum is the floor shift already truncated.
   assign result = sum[ACC_W-1:LOG2_DECIM];

   always_comb begin
      phase_next = phase_reg;
      acc_next   = acc_reg;
      if (in_valid) begin
         phase_next = phase_reg + 1'b1;
         acc_next   = (phase_reg == '0) ? in_ext : sum;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         phase_reg <= '0;
         acc_reg   <= '0;
      end else begin
         phase_reg <= phase_next;
         acc_reg   <= acc_next;
      end
   end

   // ------------------------------------------------------------------
   // FWFT FIFO
   // ------------------------------------------------------------------
   assign full = (count_reg == FULL_COUNT);
   assign pop  = out_valid && out_ready;
   // A pop on the same edge frees the slot, so a full FIFO can still accept.
   assign push = dump && (!full || pop);

   always_comb begin
      rd_ptr_next   = rd_ptr_reg;
      wr_ptr_next   = wr_ptr_reg;
      count_next    = count_reg;
      overflow_next = overflow_reg;
      if (pop)
         rd_ptr_next = rd_ptr_reg + 1'b1;
      if (push)
         wr_ptr_next = wr_ptr_reg + 1'b1;
      if (dump && !push)
         overflow_next = 1'b1;
      case ({push, pop})
         2'b10:   count_next = count_reg + 1'b1;
         2'b01:   count_next = count_reg - 1'b1;
         default: count_next = count_reg;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_reg   <= '0;
         wr_ptr_reg   <= '0;
         count_reg    <= '0;
         overflow_reg <= 1'b0;
      end else begin
         rd_ptr_reg   <= rd_ptr_next;
         wr_ptr_reg   <= wr_ptr_next;
         count_reg    <= count_next;
         overflow_reg <= overflow_next;
      end
   end

   // Storage needs no reset: out_data is masked whenever the FIFO is empty.
   always_ff @(posedge clk) begin
      if (!rst && push)
         mem[wr_ptr_reg] <= result;
   end

   assign out_valid = (count_reg != '0);
   assign out_data  = out_valid ? mem[rd_ptr_reg] : '0;
   assign count     = count_reg;
   assign overflow  = overflow_reg;

endmodule
